block_device_arbiter: RTL
=========================

// Module: block_device_arbiter
// PURPOSE
// - Shares one simulated/real block-device port (req/data/resp/info) among N_CLIENTS requesters.
// - Round-robin arbitration on req; tag widening {client_id, client_tag} downstream.
// - Write data steered in write-request order; resp demuxed by tag upper bits.
// - Sits between the block-device frontends and the single block device.
// PARAMETERS
// - N_CLIENTS  2   number of requesters (>=2)
// - ADDR_BITS  32  req addr width, passed through unchanged
// - TAG_BITS   1   per-client tag width
// - WQ_DEPTH   4   outstanding write requests awaiting data (power of 2)
// - derived: CID_BITS=$clog2(N_CLIENTS); OUT_TAG_BITS=TAG_BITS+CID_BITS
// PORTS
// - clock  in  1  single clock
// - reset  in  1  asynchronous, active-low
// - in_req_valid/ready  in/out  N  per-client req handshake
// - in_req_bits_{write,addr,offset,len,tag}  in  N*{1,ADDR_BITS,32,32,TAG_BITS}  packed, client i at slice i
// - in_data_valid/ready  in/out  N  per-client write-data handshake
// - in_data_bits_{data,tag}  in  N*{64,TAG_BITS}  packed
// - in_resp_valid/ready  out/in  N  per-client response handshake
// - in_resp_bits_{data,tag}  out  {64,TAG_BITS}  broadcast to all clients
// - in_info_{nsectors,max_req_len}  out  32 each  broadcast copy of out_info_*
// - out_req_*, out_data_*, out_resp_*, out_info_*  downstream mirror, tags OUT_TAG_BITS wide
// - tag_err  out  1  sticky: resp with client_id >= N_CLIENTS seen
// BEHAVIOUR
// - Reset (reset==0, async): rr_ptr=0, hold=0, write queue empty, beat counter=0, tag_err=0;
//   all in_*_ready, in_resp_valid, out_req_valid, out_data_valid low while in reset.
// - Req arbiter: search in_req_valid from rr_ptr upward mod N; first hit = grant.
//   out_req = granted client's fields, tag = {grant, client tag}; in_req_ready[grant]=out_req_ready.
//   If out_req_valid && !out_req_ready: register grant in hold, keep it until fire (no switching mid-stall).
//   On fire: rr_ptr <= grant+1 mod N; hold cleared. Zero cycle latency (combinational path).
// - Write ordering: a write req with len!=0 fires only if write queue not full (its valid masked
//   to arbiter when full; reads unaffected). On fire push {grant, beats=len*64}, beats 38 bits.
//   len==0 write: forwarded, no queue entry.
// - Data channel: only queue-head client's in_data passes; out_data tag={head cid, data tag};
//   other clients' in_data_ready=0. Queue empty -> out_data_valid=0, all in_data_ready=0.
//   Beat counter increments per data fire; at beats-1 fire: pop, counter<=0.
//   Push and pop same cycle on full queue: allowed (pop frees slot, push accepted).
// - Resp: cid=out_resp_bits_tag[OUT_TAG_BITS-1:TAG_BITS]; in_resp_valid[cid]=out_resp_valid;
//   out_resp_ready=in_resp_ready[cid]; in_resp_bits_tag=low TAG_BITS. cid>=N: resp sunk
//   (out_resp_ready=1), no client sees it, tag_err<=1 (sticky until reset).
// - Info: passed straight through, no registering.
// - No throughput penalty: req, data, resp channels each sustain one beat/cycle.
// STRUCTURE
// - Shared package: SECTOR_BITS=32, DATA_BITS=64, BEATS_PER_SECTOR=64, wq entry struct {cid, beats}.
// - One sub-module: block_device_write_queue (WQ_DEPTH FIFO, push/pop/full/empty/head).
// - Top: RR arbiter + hold reg, beat counter, resp demux.
// TESTING
// - Clients 0,1 req valid same cycle from reset, out_req_ready=1 -> client 0 granted first, client 1 next cycle, tags 0b0x/0b1x.
// - Client 1 req, out_req_ready=0 for 3 cycles, client 0 raises valid meanwhile -> out_req stays client 1 until fire.
// - Client 0 write len=1, then client 1 write len=2 -> exactly 64 beats from c0 then 128 from c1; c1 data blocked until c0 done.
// - WQ_DEPTH=4 writes queued, no data -> 5th write req stalled, read from other client still issued.
// - Resp tag {1,t} with in_resp_ready[1]=0 -> out_resp_ready=0; N=3, resp cid=3 -> sunk, tag_err=1.
// - Reset asserted mid-write (30 of 64 beats) -> queue empty, counter 0; after release new write needs full 64 beats.

Source files
------------

// File: rtl/block_device_arbiter_pkg.sv
// Shared types and constants for the block-device arbiter slice.
// Sector length is counted in 64-bit beats; a write of len sectors carries len*64 beats.
package block_device_arbiter_pkg;

  localparam int SECTOR_BITS      = 32;
  localparam int DATA_BITS        = 64;
  localparam int BEATS_PER_SECTOR = 64;
  localparam int BEAT_BITS        = SECTOR_BITS + $clog2(BEATS_PER_SECTOR);
  localparam int MAX_CID_BITS     = 8;

  typedef struct packed {
    logic [MAX_CID_BITS-1:0] cid;
    logic [BEAT_BITS-1:0]    beats;
  } wq_entry_t;

  function automatic logic [BEAT_BITS-1:0] len_to_beats(input logic [SECTOR_BITS-1:0] len);
    return BEAT_BITS'(len) << $clog2(BEATS_PER_SECTOR);
  endfunction

endpackage

// File: rtl/block_device_write_queue.sv
// Order-keeping FIFO of outstanding write requests awaiting their data beats.
// Zero-latency head; a push into a full queue is accepted when a pop happens in the same cycle.
module block_device_write_queue
  import block_device_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  wq_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wq_entry_t head
);

  localparam int PTR_BITS = $clog2(DEPTH);

  wq_entry_t           mem [DEPTH];
  logic [PTR_BITS:0]   wr_ptr;
  logic [PTR_BITS:0]   rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                   (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PTR_BITS-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PTR_BITS-1:0]] <= push_entry;
  end

endmodule

// File: rtl/block_device_arbiter.sv
// Shares one block-device port among N_CLIENTS: round-robin req arbitration with stall hold,
// write data steered in write-request order, responses demuxed by the widened tag's client id.
module block_device_arbiter
  import block_device_arbiter_pkg::*;
#(
  parameter int  N_CLIENTS    = 2,
  parameter int  ADDR_BITS    = 32,
  parameter int  TAG_BITS     = 1,
  parameter int  WQ_DEPTH     = 4,
  localparam int CID_BITS     = $clog2(N_CLIENTS),
  localparam int OUT_TAG_BITS = TAG_BITS + CID_BITS
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             in_req_valid,
  output logic [N_CLIENTS-1:0]             in_req_ready,
  input  logic [N_CLIENTS-1:0]             in_req_bits_write,
  input  logic [N_CLIENTS*ADDR_BITS-1:0]   in_req_bits_addr,
  input  logic [N_CLIENTS*SECTOR_BITS-1:0] in_req_bits_offset,
  input  logic [N_CLIENTS*SECTOR_BITS-1:0] in_req_bits_len,
  input  logic [N_CLIENTS*TAG_BITS-1:0]    in_req_bits_tag,
  input  logic [N_CLIENTS-1:0]             in_data_valid,
  output logic [N_CLIENTS-1:0]             in_data_ready,
  input  logic [N_CLIENTS*DATA_BITS-1:0]   in_data_bits_data,
  input  logic [N_CLIENTS*TAG_BITS-1:0]    in_data_bits_tag,
  output logic [N_CLIENTS-1:0]             in_resp_valid,
  input  logic [N_CLIENTS-1:0]             in_resp_ready,
  output logic [DATA_BITS-1:0]             in_resp_bits_data,
  output logic [TAG_BITS-1:0]              in_resp_bits_tag,
  output logic [SECTOR_BITS-1:0]           in_info_nsectors,
  output logic [SECTOR_BITS-1:0]           in_info_max_req_len,
  output logic                             out_req_valid,
  input  logic                             out_req_ready,
  output logic                             out_req_bits_write,
  output logic [ADDR_BITS-1:0]             out_req_bits_addr,
  output logic [SECTOR_BITS-1:0]           out_req_bits_offset,
  output logic [SECTOR_BITS-1:0]           out_req_bits_len,
  output logic [OUT_TAG_BITS-1:0]          out_req_bits_tag,
  output logic                             out_data_valid,
  input  logic                             out_data_ready,
  output logic [DATA_BITS-1:0]             out_data_bits_data,
  output logic [OUT_TAG_BITS-1:0]          out_data_bits_tag,
  input  logic                             out_resp_valid,
  output logic                             out_resp_ready,
  input  logic [DATA_BITS-1:0]             out_resp_bits_data,
  input  logic [OUT_TAG_BITS-1:0]          out_resp_bits_tag,
  input  logic [SECTOR_BITS-1:0]           out_info_nsectors,
  input  logic [SECTOR_BITS-1:0]           out_info_max_req_len,
  output logic                             tag_err
);

  logic [N_CLIENTS-1:0] req_elig;
  logic [CID_BITS-1:0]  rr_ptr;
  logic [CID_BITS-1:0]  hold_cid;
  logic                 hold_vld;
  logic                 hold_ok;
  logic [CID_BITS-1:0]  grant;
  logic                 found;
  int                   idx;
  logic [TAG_BITS-1:0]  req_ctag;
  logic                 req_fire;
  logic                 wq_push;
  logic                 wq_pop;
  logic                 wq_full;
  logic                 wq_empty;
  logic                 wq_can_push;
  wq_entry_t            wq_head;
  wq_entry_t            wq_new;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic                 head_vld;
  logic [CID_BITS-1:0]  head_cid;
  logic [TAG_BITS-1:0]  head_dtag;
  logic                 data_fire;
  logic [CID_BITS-1:0]  resp_cid;
  logic                 resp_cid_ok;

  // A non-empty write holds a queue slot; a same-cycle pop frees one for it.
  assign wq_can_push = !wq_full || wq_pop;

  always_comb begin
    req_elig = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      req_elig[i] = in_req_valid[i] &&
                    !(in_req_bits_write[i] &&
                      (in_req_bits_len[i*SECTOR_BITS +: SECTOR_BITS] != '0) &&
                      !wq_can_push);
    end
  end

  always_comb begin
    hold_ok = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (hold_vld && hold_cid == CID_BITS'(i) && req_elig[i]) hold_ok = 1'b1;
    end
  end

  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = 0;
    if (hold_ok) begin
      found = 1'b1;
      grant = hold_cid;
    end else begin
      for (int k = 0; k < N_CLIENTS; k++) begin
        idx = (int'(rr_ptr) + k) % N_CLIENTS;
        if (!found && req_elig[idx]) begin
          found = 1'b1;
          grant = CID_BITS'(idx);
        end
      end
    end
  end

  always_comb begin
    out_req_bits_write  = 1'b0;
    out_req_bits_addr   = '0;
    out_req_bits_offset = '0;
    out_req_bits_len    = '0;
    req_ctag            = '0;
    in_req_ready        = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant == CID_BITS'(i)) begin
        out_req_bits_write  = in_req_bits_write[i];
        out_req_bits_addr   = in_req_bits_addr[i*ADDR_BITS +: ADDR_BITS];
        out_req_bits_offset = in_req_bits_offset[i*SECTOR_BITS +: SECTOR_BITS];
        out_req_bits_len    = in_req_bits_len[i*SECTOR_BITS +: SECTOR_BITS];
        req_ctag            = in_req_bits_tag[i*TAG_BITS +: TAG_BITS];
        in_req_ready[i]     = reset && found && out_req_ready;
      end
    end
  end

  assign out_req_valid    = reset && found;
  assign out_req_bits_tag = {grant, req_ctag};
  assign req_fire         = out_req_valid && out_req_ready;
  assign wq_push          = req_fire && out_req_bits_write && (out_req_bits_len != '0);
  assign wq_new           = '{cid: MAX_CID_BITS'(grant), beats: len_to_beats(out_req_bits_len)};

  block_device_write_queue #(.DEPTH(WQ_DEPTH)) u_wq (
    .clock      (clock),
    .reset      (reset),
    .push       (wq_push),
    .push_entry (wq_new),
    .pop        (wq_pop),
    .full       (wq_full),
    .empty      (wq_empty),
    .head       (wq_head)
  );

  // Only the client owning the oldest outstanding write may move data.
  always_comb begin
    head_vld           = 1'b0;
    head_cid           = '0;
    head_dtag          = '0;
    out_data_bits_data = '0;
    in_data_ready      = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (!wq_empty && wq_head.cid == MAX_CID_BITS'(i)) begin
        head_vld           = in_data_valid[i];
        head_cid           = CID_BITS'(i);
        head_dtag          = in_data_bits_tag[i*TAG_BITS +: TAG_BITS];
        out_data_bits_data = in_data_bits_data[i*DATA_BITS +: DATA_BITS];
        in_data_ready[i]   = reset && out_data_ready;
      end
    end
  end

  assign out_data_valid    = reset && head_vld;
  assign out_data_bits_tag = {head_cid, head_dtag};
  assign data_fire         = out_data_valid && out_data_ready;
  assign wq_pop            = data_fire && (beat_cnt == wq_head.beats - 1'b1);

  assign resp_cid = out_resp_bits_tag[OUT_TAG_BITS-1:TAG_BITS];

  // Unknown client ids are drained so the device never stalls on them.
  always_comb begin
    resp_cid_ok    = 1'b0;
    in_resp_valid  = '0;
    out_resp_ready = 1'b1;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (resp_cid == CID_BITS'(i)) begin
        resp_cid_ok      = 1'b1;
        in_resp_valid[i] = reset && out_resp_valid;
        out_resp_ready   = in_resp_ready[i];
      end
    end
  end

  assign in_resp_bits_data   = out_resp_bits_data;
  assign in_resp_bits_tag    = out_resp_bits_tag[TAG_BITS-1:0];
  assign in_info_nsectors    = out_info_nsectors;
  assign in_info_max_req_len = out_info_max_req_len;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      hold_vld <= 1'b0;
      hold_cid <= '0;
      beat_cnt <= '0;
      tag_err  <= 1'b0;
    end else begin
      if (req_fire) begin
        hold_vld <= 1'b0;
        rr_ptr   <= (int'(grant) == N_CLIENTS - 1) ? '0 : grant + 1'b1;
      end else if (out_req_valid) begin
        hold_vld <= 1'b1;
        hold_cid <= grant;
      end
      if (data_fire) beat_cnt <= wq_pop ? '0 : beat_cnt + 1'b1;
      if (out_resp_valid && !resp_cid_ok) tag_err <= 1'b1;
    end
  end

endmodule
